// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder
// Purpose  : Multi-cycle WIDTH-bit adder/subtractor sequencer. It wraps an
//            external 4-bit carry-lookahead adder and walks it across the
//            operands one nibble per cycle, LSB first, chaining the carry.
// Ports    : clk, rst_n          - clock (rising edge), async active-low reset
//            in_valid/in_ready   - operand handshake (in_a, in_b, in_cin, in_sub)
//            cla_a/cla_b/cla_cin - nibble operands and carry toward the CLA
//            cla_s/cla_cout      - CLA result, combinational from cla_*
//            out_valid/out_ready - result handshake (out_sum, out_cout, out_ovf)
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic [3:0]       cla_a,
  output logic [3:0]       cla_b,
  output logic             cla_cin,
  input  logic [3:0]       cla_s,
  input  logic             cla_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(NIB - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;     // effective B: already inverted for subtraction
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  logic             w_run;
  logic             w_done;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;

  assign w_run  = (r_state == S_RUN);
  assign w_done = (r_state == S_DONE);

  // Nibble select from the operand registers only, so the CLA never sees a
  // combinational path from the upstream inputs.
  always_comb begin
    w_a_nib = 4'd0;
    w_b_nib = 4'd0;
    for (int n = 0; n < NIB; n++) begin
      if (r_idx == IDXW'(n)) begin
        w_a_nib = r_a[4*n +: 4];
        w_b_nib = r_b[4*n +: 4];
      end
    end
  end

  assign cla_a   = w_run ? w_a_nib : 4'd0;
  assign cla_b   = w_run ? w_b_nib : 4'd0;
  assign cla_cin = w_run ? r_carry : 1'b0;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = w_done;
  assign out_sum   = w_done ? r_sum : '0;
  assign out_cout  = w_done ? r_carry : 1'b0;
  // Signed overflow: both addends share a sign and the result sign differs.
  assign out_ovf   = w_done & (r_a[WIDTH-1] == r_b[WIDTH-1]) &
                     (r_sum[WIDTH-1] != r_a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_sub ? ~in_b : in_b;
            // Subtraction is A + ~B + 1; in_cin only matters when adding.
            r_carry <= in_sub | in_cin;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int n = 0; n < NIB; n++) begin
            if (r_idx == IDXW'(n)) begin
              r_sum[4*n +: 4] <= cla_s;
            end
          end
          r_carry <= cla_cout;
          if (r_idx == c_LAST_IDX) begin
            r_idx   <= '0;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle W-bit adder/subtractor sequencer, placed directly around the team's 4-bit carry-lookahead adder.
- Upstream side: latches W-bit operands through a valid/ready handshake.
- Toward the CLA: feeds it one nibble per cycle (LSB first) on cla_a/cla_b/cla_cin, then captures cla_s/cla_cout and chains the carry.
- Downstream side: presents the assembled sum, carry-out and signed overflow through a valid/ready handshake.

Parameters:
- WIDTH, 16, operand/result width in bits; multiple of 4, >= 4. NIB = WIDTH/4 nibble steps.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept operands
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in (add mode only)
- in_sub  input  1  1 = compute A - B
- cla_a  output  4  nibble of A to CLA
- cla_b  output  4  nibble of effective B to CLA
- cla_cin  output  1  chained carry to CLA
- cla_s  input  4  CLA sum nibble (combinational from cla_*)
- cla_cout  input  1  CLA carry-out
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  result
- out_cout  output  1  final carry-out (add: carry; sub: 1 = no borrow)
- out_ovf  output  1  two's-complement overflow

Behaviour:
- Reset: async on rst_n low, all state cleared immediately, no clock needed.
  - State = IDLE, in_ready = 1, out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0.
  - cla_a = 0, cla_b = 0, cla_cin = 0. Nibble index = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On edge with in_valid & in_ready: latch a_reg = in_a, b_reg = in_sub ? ~in_b : in_b, carry = in_sub ? 1 : in_cin, sub_reg = in_sub; idx = 0; go to RUN.
- RUN:
  - in_ready = 0.
  - cla_a = a_reg[4*idx+3:4*idx], cla_b = b_reg[4*idx+3:4*idx], cla_cin = carry; all driven directly from registers, no combinational path from in_*.
  - Each edge: sum_reg[4*idx+3:4*idx] <= cla_s, carry <= cla_cout, idx <= idx+1.
  - On the edge where idx == NIB-1: go to DONE.
- DONE:
  - out_valid = 1; out_sum = sum_reg, out_cout = carry.
  - out_ovf = (a_reg[W-1] == b_reg[W-1]) & (sum_reg[W-1] != a_reg[W-1]).
  - All outputs held stable while out_ready = 0.
  - On edge with out_valid & out_ready: go to IDLE, out_valid = 0.
- cla_a/cla_b/cla_cin are 0 in IDLE and DONE.
- Latency: operands accepted at edge k give out_valid = 1 after edge k+NIB. Throughput is one operation per NIB+2 cycles minimum.
- No bypass: in_ready rises only in the cycle after the output handshake. in_valid while in_ready = 0 is ignored and not queued.
- Operands are sampled only at the accept edge; later changes on in_* have no effect.
- in_ready is a state decode (IDLE); out_valid is a state decode (DONE). Neither depends combinationally on in_valid or out_ready.
- idx register width = clog2(NIB), minimum 1. Wrap-around beyond NIB-1 is not reachable.
- WIDTH = 4: a single RUN cycle.
- Reset asserted mid-RUN or in DONE: the operation is aborted, the result is discarded, and no out_valid follows reset release.

Test Plan (WIDTH=16, model CLA in bench as a 4-bit add):
- Add 0x1234 + 0x4321, cin=0 -> out_sum 0x5555, cout 0, ovf 0. out_valid exactly 4 cycles after accept. cla_a sequence 4,3,2,1.
- Add 0xFFFF + 0x0001, cin=0 -> 0x0000, cout 1, ovf 0. cla_cin sequence 0,1,1,1. Add 0x0000 + 0x0000, cin=1 -> 0x0001.
- Add 0x7FFF + 0x0001 -> 0x8000, cout 0, ovf 1. Sub 0x8000 - 0x0001 -> 0x7FFF, cout 1, ovf 1.
- Sub 0x0005 - 0x0007 -> 0xFFFE, cout 0, ovf 0; in_cin = 1 is ignored in sub mode.
- Hold out_ready = 0 for 5 cycles in DONE, with in_valid held high carrying new operands -> outputs stable, in_ready 0, nothing accepted. Raise out_ready -> IDLE next cycle, then the new operands are accepted.
- Pulse rst_n low mid-RUN (idx = 2) -> all outputs 0 immediately, in_ready 1 after release, no out_valid. A following add of 0x00FF + 0x0001 -> 0x0100.
